// File: rtl/stopwatch_timebase_if.sv
// Strobe and display bundle between the stopwatch control FSM (master)
// and the centisecond timebase datapath (slave).
interface stopwatch_timebase_if;
  logic        en_i;
  logic        update_i;
  logic        clr_i;
  logic [23:0] disp_o;
  logic        tick_o;
  logic        wrap_o;

  modport master (
    output en_i,
    output update_i,
    output clr_i,
    input  disp_o,
    input  tick_o,
    input  wrap_o
  );

  modport slave (
    input  en_i,
    input  update_i,
    input  clr_i,
    output disp_o,
    output tick_o,
    output wrap_o
  );
endinterface

// File: rtl/stopwatch_timebase.sv
// Centisecond prescaler, BCD MM:SS.CC time counter and split-freezable
// display latch feeding the 7-segment multiplexer.
module stopwatch_timebase #(
  parameter int TICK_DIV = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  stopwatch_timebase_if.slave  bus
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

  // Digit limits, index 0 = centisecond units up to 5 = minute tens.
  localparam logic [3:0] DIGIT_MAX [6] = '{4'd9, 4'd9, 4'd9, 4'd5, 4'd9, 4'd5};

  logic [DIV_W-1:0] div_cnt;
  logic [23:0]      cur_time;
  logic [23:0]      time_inc;
  logic             rollover;
  logic [23:0]      disp_q;
  logic             tick_q;
  logic             wrap_q;

  // Ripple a single increment through the six BCD digits; a carry out of
  // the minute tens digit means 59:59.99 has just rolled to zero.
  always_comb begin
    logic carry;
    time_inc = cur_time;
    carry    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (cur_time[i*4 +: 4] >= DIGIT_MAX[i]) begin
          time_inc[i*4 +: 4] = 4'd0;
        end else begin
          time_inc[i*4 +: 4] = cur_time[i*4 +: 4] + 4'd1;
          carry              = 1'b0;
        end
      end
    end
    rollover = carry;
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clr_i) begin
      div_cnt  <= '0;
      cur_time <= '0;
      disp_q   <= '0;
      tick_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      if (bus.en_i) begin
        if (div_cnt == DIV_MAX) begin
          div_cnt  <= '0;
          cur_time <= time_inc;
          tick_q   <= 1'b1;
          wrap_q   <= rollover;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end
      // The display takes the pre-edge time, so it trails the counter by one cycle.
      if (bus.update_i) begin
        disp_q <= cur_time;
      end
    end
  end

  assign bus.disp_o = disp_q;
  assign bus.tick_o = tick_q;
  assign bus.wrap_o = wrap_q;

endmodule

// File: tb/tb_stopwatch_timebase.sv
// Directed bench for stopwatch_timebase: a TICK_DIV=4 instance for the
// prescaler/latch/clear behaviour and a TICK_DIV=1 instance for full rollover.
module tb_stopwatch_timebase;

  logic clk;
  logic rst4;
  logic rst1;
  int   checks;
  int   fails;

  stopwatch_timebase_if if4 ();
  stopwatch_timebase_if if1 ();

  stopwatch_timebase #(.TICK_DIV(4)) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (if4.slave)
  );

  stopwatch_timebase #(.TICK_DIV(1)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset4();
    rst4 = 1'b1;
    if4.en_i = 1'b0;
    if4.update_i = 1'b0;
    if4.clr_i = 1'b0;
    step();
    rst4 = 1'b0;
  endtask

  task automatic test_reset();
    rst4 = 1'b1;
    repeat (3) step();
    rst4 = 1'b0;
    checks++;
    if (if4.disp_o !== 24'h000000) begin
      fails++;
      $display("[TB] FAIL reset_disp: got %h expected %h", if4.disp_o, 24'h000000);
    end
    checks++;
    if (if4.tick_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_tick: got %b expected 0", if4.tick_o);
    end
    checks++;
    if (if4.wrap_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_wrap: got %b expected 0", if4.wrap_o);
    end
  endtask

  task automatic test_count();
    int ticks;
    logic exp_tick;
    ticks = 0;
    if4.en_i = 1'b1;
    if4.update_i = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      exp_tick = (i % 4 == 0);
      if (if4.tick_o === 1'b1) ticks++;
      checks++;
      if (if4.tick_o !== exp_tick) begin
        fails++;
        $display("[TB] FAIL count_tick cycle %0d: got %b expected %b", i, if4.tick_o, exp_tick);
      end
    end
    checks++;
    if (ticks != 10) begin
      fails++;
      $display("[TB] FAIL count_ticks_total: got %0d expected 10", ticks);
    end
    if4.en_i = 1'b0;
    step();
    checks++;
    if (if4.disp_o !== 24'h000010) begin
      fails++;
      $display("[TB] FAIL count_disp: got %h expected %h", if4.disp_o, 24'h000010);
    end
  endtask

  task automatic test_pause();
    reset4();
    if4.en_i = 1'b1;
    if4.update_i = 1'b1;
    repeat (6) step();
    if4.en_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (if4.tick_o !== 1'b0) begin
        fails++;
        $display("[TB] FAIL pause_tick cycle %0d: got %b expected 0", i, if4.tick_o);
      end
    end
    if4.en_i = 1'b1;
    step();
    checks++;
    if (if4.tick_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL pause_resume1_tick: got %b expected 0", if4.tick_o);
    end
    step();
    checks++;
    if (if4.tick_o !== 1'b1) begin
      fails++;
      $display("[TB] FAIL pause_resume2_tick: got %b expected 1", if4.tick_o);
    end
    if4.en_i = 1'b0;
    step();
    checks++;
    if (if4.disp_o !== 24'h000002) begin
      fails++;
      $display("[TB] FAIL pause_disp: got %h expected %h", if4.disp_o, 24'h000002);
    end
  endtask

  task automatic test_split();
    reset4();
    if4.en_i = 1'b1;
    if4.update_i = 1'b1;
    repeat (21) step();
    checks++;
    if (if4.disp_o !== 24'h000005) begin
      fails++;
      $display("[TB] FAIL split_pre_disp: got %h expected %h", if4.disp_o, 24'h000005);
    end
    if4.update_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (if4.disp_o !== 24'h000005) begin
        fails++;
        $display("[TB] FAIL split_hold cycle %0d: got %h expected %h", i, if4.disp_o, 24'h000005);
      end
    end
    if4.update_i = 1'b1;
    step();
    checks++;
    if (if4.disp_o !== 24'h000010) begin
      fails++;
      $display("[TB] FAIL split_release_disp: got %h expected %h", if4.disp_o, 24'h000010);
    end
  endtask

  task automatic test_clear();
    reset4();
    if4.en_i = 1'b1;
    if4.update_i = 1'b1;
    repeat (7) step();
    if4.clr_i = 1'b1;
    step();
    if4.clr_i = 1'b0;
    checks++;
    if (if4.tick_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL clear_tick: got %b expected 0", if4.tick_o);
    end
    checks++;
    if (if4.wrap_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL clear_wrap: got %b expected 0", if4.wrap_o);
    end
    checks++;
    if (if4.disp_o !== 24'h000000) begin
      fails++;
      $display("[TB] FAIL clear_disp: got %h expected %h", if4.disp_o, 24'h000000);
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (if4.tick_o !== (i == 4)) begin
        fails++;
        $display("[TB] FAIL clear_resume_tick cycle %0d: got %b expected %b", i, if4.tick_o, (i == 4));
      end
    end
    if4.en_i = 1'b0;
    step();
    checks++;
    if (if4.disp_o !== 24'h000001) begin
      fails++;
      $display("[TB] FAIL clear_resume_disp: got %h expected %h", if4.disp_o, 24'h000001);
    end
  endtask

  task automatic test_wrap();
    int wraps;
    wraps = 0;
    rst1 = 1'b1;
    if1.en_i = 1'b0;
    if1.update_i = 1'b0;
    if1.clr_i = 1'b0;
    repeat (2) step();
    rst1 = 1'b0;
    if1.en_i = 1'b1;
    if1.update_i = 1'b1;
    for (int i = 1; i <= 359999; i++) begin
      step();
      if (if1.wrap_o === 1'b1) wraps++;
      if (i == 6000) begin
        checks++;
        if (if1.disp_o !== 24'h005999) begin
          fails++;
          $display("[TB] FAIL wrap_minute_carry_disp: got %h expected %h", if1.disp_o, 24'h005999);
        end
      end
    end
    checks++;
    if (wraps != 0) begin
      fails++;
      $display("[TB] FAIL wrap_early: got %0d pulses expected 0", wraps);
    end
    step();
    checks++;
    if (if1.disp_o !== 24'h595999) begin
      fails++;
      $display("[TB] FAIL wrap_full_disp: got %h expected %h", if1.disp_o, 24'h595999);
    end
    checks++;
    if (if1.wrap_o !== 1'b1 || if1.tick_o !== 1'b1) begin
      fails++;
      $display("[TB] FAIL wrap_pulse: got wrap=%b tick=%b expected wrap=1 tick=1", if1.wrap_o, if1.tick_o);
    end
    step();
    checks++;
    if (if1.disp_o !== 24'h000000) begin
      fails++;
      $display("[TB] FAIL wrap_zero_disp: got %h expected %h", if1.disp_o, 24'h000000);
    end
    checks++;
    if (if1.wrap_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL wrap_single_pulse: got %b expected 0", if1.wrap_o);
    end
  endtask

  initial begin
    checks = 0;
    fails = 0;
    rst4 = 1'b1;
    rst1 = 1'b1;
    if4.en_i = 1'b0;
    if4.update_i = 1'b0;
    if4.clr_i = 1'b0;
    if1.en_i = 1'b0;
    if1.update_i = 1'b0;
    if1.clr_i = 1'b0;
    test_reset();
    test_count();
    test_pause();
    test_split();
    test_clear();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/stopwatch_timebase.md
Name: stopwatch_timebase

Overview:
- Datapath stage directly downstream of the stopwatch control FSM.
- Consumes the FSM's count-enable (en) and display-update (update) strobes.
- Keeps a running BCD time MM:SS.CC with a centisecond prescaler.
- Drives a display latch that freezes during split and feeds the 7-segment multiplexer.

Parameters:
- TICK_DIV, 1000000, clk cycles per centisecond tick (100 MHz clock). Legal range >= 1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- en_i  in  1  count enable from control FSM.
- update_i  in  1  display-latch enable from control FSM; 0 = hold (split).
- clr_i  in  1  synchronous clear of time and display; 1-cycle pulse or level.
- disp_o  out  24  latched display value: [23:20] min tens, [19:16] min units, [15:12] sec tens, [11:8] sec units, [7:4] cs tens, [3:0] cs units; all BCD.
- tick_o  out  1  registered 1-cycle pulse on each centisecond increment.
- wrap_o  out  1  registered 1-cycle pulse when time rolls 59:59.99 -> 00:00.00.

Behaviour:
- Reset is synchronous, active-high; single clock domain.
- Reset values: disp_o=0, tick_o=0, wrap_o=0, internal time=0, prescaler=0.
- Priority per edge: rst > clr_i > count/latch.

Prescaler (div_cnt):
- Width max(1, clog2(TICK_DIV)).
- en_i=1 and div_cnt<TICK_DIV-1: div_cnt+1.
- en_i=1 and div_cnt==TICK_DIV-1: div_cnt<=0 and time increments same edge; tick_o=1 next cycle.
- en_i=0: div_cnt and time hold (pause keeps partial count); tick_o=0.
- TICK_DIV=1: every enabled cycle is a tick.

Time increment (BCD carry chain):
- cs units 9->0 carries to cs tens; cs tens 9->0 carries to sec units.
- sec units 9->0 carries to sec tens; sec tens 5->0 carries to min units.
- min units 9->0 carries to min tens; min tens 5->0 = full rollover, wrap_o=1 with the tick.
- No digit ever holds a value outside its legal range (0-9, tens of sec/min 0-5).

Display latch:
- Edge with update_i=1: disp_o <= time value held before that edge, i.e. one cycle behind internal time.
- update_i=0: disp_o holds. Counting continues independent of update_i.

clr_i:
- Zeros time, div_cnt and disp_o.
- Forces tick_o=0 and wrap_o=0 that edge, even if a tick was due.

Misc:
- tick_o, wrap_o, disp_o are registered; no combinational input-to-output path.
- en_i and update_i are used as-is; the upstream FSM guarantees they are synchronous to clk.

Test Plan:
- TICK_DIV=4; assert rst 3 cycles, then release -> disp_o=24'h000000, tick_o=0, wrap_o=0.
- en_i=1, update_i=1 for 40 cycles -> 10 tick_o pulses, one every 4th cycle; disp_o=24'h000010 one cycle after the 10th tick.
- en_i=1 for 6 cycles (1 tick, div_cnt=2), en_i=0 for 10 cycles, then en_i=1 -> next tick_o exactly 2 enabled cycles later; disp_o=24'h000002 one cycle after.
- Count to disp_o=24'h000005, drop update_i for 20 enabled cycles -> disp_o stays 24'h000005; raise update_i -> disp_o=24'h000010 next cycle.
- TICK_DIV=1, en_i=1, update_i=1 for 359999 cycles -> internal time 59:59.99, disp_o=24'h595999 one cycle later; next cycle wrap_o=1, tick_o=1, then disp_o=24'h000000.
- TICK_DIV=4, clr_i=1 on the cycle div_cnt==3 with en_i=1 -> no tick_o pulse; time, div_cnt, disp_o all 0; counting resumes, first tick after 4 enabled cycles.
